// File: rtl/axi4_lite_splitter.sv
// AXI4-Lite 1:N register splitter.
// One transaction in flight, decoded by upper address bits.
module axi4_lite_splitter #(
  parameter int NUM_SLAVES         = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 16,
  parameter int SLAVE_ADDR_WIDTH   = 6
) (
  input  logic                                      S_AXI_ACLK,
  input  logic                                      S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]             S_AXI_AWADDR,
  input  logic [2:0]                                S_AXI_AWPROT,
  input  logic                                      S_AXI_AWVALID,
  output logic                                      S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]             S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]           S_AXI_WSTRB,
  input  logic                                      S_AXI_WVALID,
  output logic                                      S_AXI_WREADY,
  output logic [1:0]                                S_AXI_BRESP,
  output logic                                      S_AXI_BVALID,
  input  logic                                      S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]             S_AXI_ARADDR,
  input  logic [2:0]                                S_AXI_ARPROT,
  input  logic                                      S_AXI_ARVALID,
  output logic                                      S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]             S_AXI_RDATA,
  output logic [1:0]                                S_AXI_RRESP,
  output logic                                      S_AXI_RVALID,
  input  logic                                      S_AXI_RREADY,
  output logic [NUM_SLAVES*SLAVE_ADDR_WIDTH-1:0]    M_AXI_AWADDR,
  output logic [NUM_SLAVES*3-1:0]                   M_AXI_AWPROT,
  output logic [NUM_SLAVES-1:0]                     M_AXI_AWVALID,
  input  logic [NUM_SLAVES-1:0]                     M_AXI_AWREADY,
  output logic [NUM_SLAVES*C_S_AXI_DATA_WIDTH-1:0]  M_AXI_WDATA,
  output logic [NUM_SLAVES*C_S_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic [NUM_SLAVES-1:0]                     M_AXI_WVALID,
  input  logic [NUM_SLAVES-1:0]                     M_AXI_WREADY,
  input  logic [NUM_SLAVES*2-1:0]                   M_AXI_BRESP,
  input  logic [NUM_SLAVES-1:0]                     M_AXI_BVALID,
  output logic [NUM_SLAVES-1:0]                     M_AXI_BREADY,
  output logic [NUM_SLAVES*SLAVE_ADDR_WIDTH-1:0]    M_AXI_ARADDR,
  output logic [NUM_SLAVES*3-1:0]                   M_AXI_ARPROT,
  output logic [NUM_SLAVES-1:0]                     M_AXI_ARVALID,
  input  logic [NUM_SLAVES-1:0]                     M_AXI_ARREADY,
  input  logic [NUM_SLAVES*C_S_AXI_DATA_WIDTH-1:0]  M_AXI_RDATA,
  input  logic [NUM_SLAVES*2-1:0]                   M_AXI_RRESP,
  input  logic [NUM_SLAVES-1:0]                     M_AXI_RVALID,
  output logic [NUM_SLAVES-1:0]                     M_AXI_RREADY
);

  localparam int N   = NUM_SLAVES;
  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int AW  = C_S_AXI_ADDR_WIDTH;
  localparam int SAW = SLAVE_ADDR_WIDTH;
  localparam int SW  = DW / 8;
  localparam int IXW = AW - SAW;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [3:0] {
    IDLE,
    W_ACC,
    W_FWD,
    W_WAIT,
    W_RESP,
    R_ACC,
    R_FWD,
    R_WAIT,
    R_RESP
  } state_t;

  typedef enum logic {
    GR_RD = 1'b0,
    GR_WR = 1'b1
  } grant_t;

  state_t         state_q;
  grant_t         last_q;
  logic [IW-1:0]  sel_q;
  logic [SAW-1:0] addr_q;
  logic [2:0]     prot_q;
  logic [DW-1:0]  wdata_q;
  logic [SW-1:0]  wstrb_q;
  logic           awv_q;
  logic           wv_q;
  logic           arv_q;
  logic           bready_q;
  logic           rready_q;
  logic           awready_q;
  logic           wready_q;
  logic           arready_q;
  logic           bvalid_q;
  logic           rvalid_q;
  logic [1:0]     bresp_q;
  logic [1:0]     rresp_q;
  logic [DW-1:0]  rdata_q;

  logic           wr_req;
  logic           rd_req;
  logic [IXW-1:0] aw_ix;
  logic [IXW-1:0] ar_ix;
  logic           aw_hit;
  logic           ar_hit;
  logic [N-1:0]   sel_oh;
  logic [1:0]     m_bresp;
  logic [1:0]     m_rresp;
  logic [DW-1:0]  m_rdata;
  logic           aw_fire;
  logic           w_fire;
  logic           aw_done;
  logic           w_done;

  assign wr_req = S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_req = S_AXI_ARVALID;
  assign aw_ix  = S_AXI_AWADDR[AW-1:SAW];
  assign ar_ix  = S_AXI_ARADDR[AW-1:SAW];
  assign aw_hit = aw_ix < IXW'(N);
  assign ar_hit = ar_ix < IXW'(N);

  // one-hot of the latched slave and its response fields
  always_comb begin
    sel_oh  = '0;
    m_bresp = '0;
    m_rresp = '0;
    m_rdata = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_q == IW'(i)) begin
        sel_oh[i] = 1'b1;
        m_bresp   = M_AXI_BRESP[i*2 +: 2];
        m_rresp   = M_AXI_RRESP[i*2 +: 2];
        m_rdata   = M_AXI_RDATA[i*DW +: DW];
      end
    end
  end

  assign aw_fire = awv_q & |(M_AXI_AWREADY & sel_oh);
  assign w_fire  = wv_q & |(M_AXI_WREADY & sel_oh);
  assign aw_done = ~awv_q | aw_fire;
  assign w_done  = ~wv_q | w_fire;

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

  assign M_AXI_AWADDR  = {N{addr_q}};
  assign M_AXI_ARADDR  = {N{addr_q}};
  assign M_AXI_AWPROT  = {N{prot_q}};
  assign M_AXI_ARPROT  = {N{prot_q}};
  assign M_AXI_WDATA   = {N{wdata_q}};
  assign M_AXI_WSTRB   = {N{wstrb_q}};
  assign M_AXI_AWVALID = sel_oh & {N{awv_q}};
  assign M_AXI_WVALID  = sel_oh & {N{wv_q}};
  assign M_AXI_ARVALID = sel_oh & {N{arv_q}};
  assign M_AXI_BREADY  = sel_oh & {N{bready_q}};
  assign M_AXI_RREADY  = sel_oh & {N{rready_q}};

  // transaction FSM; the grant memory only moves when both types compete
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q   <= IDLE;
      last_q    <= GR_RD;
      sel_q     <= '0;
      addr_q    <= '0;
      prot_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awv_q     <= 1'b0;
      wv_q      <= 1'b0;
      arv_q     <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_req && (!rd_req || last_q == GR_RD)) begin
            state_q   <= W_ACC;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            if (rd_req) last_q <= GR_WR;
          end else if (rd_req) begin
            state_q   <= R_ACC;
            arready_q <= 1'b1;
            if (wr_req) last_q <= GR_RD;
          end
        end
        W_ACC: begin
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
          addr_q    <= S_AXI_AWADDR[SAW-1:0];
          prot_q    <= S_AXI_AWPROT;
          wdata_q   <= S_AXI_WDATA;
          wstrb_q   <= S_AXI_WSTRB;
          sel_q     <= aw_ix[IW-1:0];
          if (aw_hit) begin
            state_q <= W_FWD;
            awv_q   <= 1'b1;
            wv_q    <= 1'b1;
          end else begin
            state_q  <= W_RESP;
            bvalid_q <= 1'b1;
            bresp_q  <= 2'b11;
          end
        end
        W_FWD: begin
          if (aw_fire) awv_q <= 1'b0;
          if (w_fire) wv_q <= 1'b0;
          if (aw_done && w_done) begin
            state_q  <= W_WAIT;
            bready_q <= 1'b1;
          end
        end
        W_WAIT: begin
          if (|(M_AXI_BVALID & sel_oh)) begin
            state_q  <= W_RESP;
            bready_q <= 1'b0;
            bresp_q  <= m_bresp;
            bvalid_q <= 1'b1;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            state_q  <= IDLE;
            bvalid_q <= 1'b0;
          end
        end
        R_ACC: begin
          arready_q <= 1'b0;
          addr_q    <= S_AXI_ARADDR[SAW-1:0];
          prot_q    <= S_AXI_ARPROT;
          sel_q     <= ar_ix[IW-1:0];
          if (ar_hit) begin
            state_q <= R_FWD;
            arv_q   <= 1'b1;
          end else begin
            state_q  <= R_RESP;
            rvalid_q <= 1'b1;
            rresp_q  <= 2'b11;
            rdata_q  <= '0;
          end
        end
        R_FWD: begin
          if (|(M_AXI_ARREADY & sel_oh)) begin
            state_q  <= R_WAIT;
            arv_q    <= 1'b0;
            rready_q <= 1'b1;
          end
        end
        R_WAIT: begin
          if (|(M_AXI_RVALID & sel_oh)) begin
            state_q  <= R_RESP;
            rready_q <= 1'b0;
            rresp_q  <= m_rresp;
            rdata_q  <= m_rdata;
            rvalid_q <= 1'b1;
          end
        end
        R_RESP: begin
          if (S_AXI_RREADY) begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
